// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: raises stall/flush for the decode-stage mux and
// derives the PC and IF/ID write enables. Also keeps saturating stall/flush counters.
module hazard_control_unit #(
  parameter int MULDIV_LATENCY = 4,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             ex_muldiv_start,
  input  logic             branch_taken,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_pc_write_en,
  output logic             o_if_id_write_en,
  output logic             o_muldiv_busy,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_cycles
);

  localparam int CNT_MAX = (MULDIV_LATENCY > FLUSH_CYCLES) ? MULDIV_LATENCY : FLUSH_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  // The cycle that starts a mul/div or takes a branch is already served from
  // IDLE, so the down-counter only covers the remaining cycles minus one.
  localparam bit            MULDIV_MULTI = (MULDIV_LATENCY > 1);
  localparam bit            FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [CW-1:0] MULDIV_INIT  = MULDIV_MULTI ? CW'(MULDIV_LATENCY - 2) : '0;
  localparam logic [CW-1:0] FLUSH_INIT   = FLUSH_MULTI  ? CW'(FLUSH_CYCLES - 2)   : '0;

  typedef enum logic [1:0] {IDLE, MULDIV, FLUSH} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic            lu;
  logic [CNT_W-1:0] cnt_max_val;

  assign cnt_max_val = {CNT_W{1'b1}};

  assign lu = id_valid & ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // In IDLE a taken branch outranks a mul/div start, which outranks a load-use stall.
  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    o_stall       = 1'b0;
    o_flush       = 1'b0;
    o_muldiv_busy = 1'b0;
    case (state)
      IDLE: begin
        if (branch_taken) begin
          o_flush = 1'b1;
          if (FLUSH_MULTI) begin
            next_state = FLUSH;
            next_cnt   = FLUSH_INIT;
          end
        end else if (ex_muldiv_start) begin
          o_stall = 1'b1;
          if (MULDIV_MULTI) begin
            next_state = MULDIV;
            next_cnt   = MULDIV_INIT;
          end
        end else if (lu) begin
          o_stall = 1'b1;
        end
      end
      MULDIV: begin
        o_stall       = 1'b1;
        o_muldiv_busy = 1'b1;
        if (cnt == '0) next_state = IDLE;
        else           next_cnt   = cnt - CW'(1);
      end
      FLUSH: begin
        o_flush = 1'b1;
        if (cnt == '0) next_state = IDLE;
        else           next_cnt   = cnt - CW'(1);
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign o_pc_write_en    = ~o_stall;
  assign o_if_id_write_en = ~o_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cycles <= '0;
      o_flush_cycles <= '0;
    end else begin
      if (o_stall && (o_stall_cycles != cnt_max_val))
        o_stall_cycles <= o_stall_cycles + CNT_W'(1);
      if (o_flush && (o_flush_cycles != cnt_max_val))
        o_flush_cycles <= o_flush_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Generates the `stall` and `flush` qualifiers consumed by the decode-stage control mux. It also generates the matching PC and IF/ID write enables.
- Detects load-use hazards combinationally.
- Holds the front end while a multi-cycle mul/div occupies EX.
- Keeps flush asserted for a programmable number of cycles after a taken branch.
- Keeps saturating performance counters of stall and flush cycles.

Parameters:
- MULDIV_LATENCY, 4: total EX occupancy of a mul/div in cycles. Legal range ≥1.
- FLUSH_CYCLES, 2: number of consecutive cycles `o_flush` is asserted per taken branch. Legal range ≥1.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes rd
- ex_rd  in  5  EX destination register
- ex_muldiv_start  in  1  one-cycle pulse: a mul/div entered EX this cycle
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- o_stall  out  1  to decode control mux; insert bubble, hold ID
- o_flush  out  1  to decode control mux; squash ID
- o_pc_write_en  out  1  PC register write enable
- o_if_id_write_en  out  1  IF/ID register write enable
- o_muldiv_busy  out  1  FSM is in MULDIV
- o_stall_cycles  out  CNT_W  saturating count of cycles with `o_stall`=1
- o_flush_cycles  out  CNT_W  saturating count of cycles with `o_flush`=1

Behaviour:
- FSM states: IDLE, MULDIV, FLUSH. A down-counter `cnt` is sized to hold max(MULDIV_LATENCY, FLUSH_CYCLES).
- Reset (synchronous, active-high):
  - state=IDLE, cnt=0, both perf counters=0.
  - With all inputs at 0: o_stall=0, o_flush=0, o_pc_write_en=1, o_if_id_write_en=1, o_muldiv_busy=0.
- Load-use hazard, `lu`:
  - lu = id_valid & ex_mem_read & ex_reg_write & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Combinational, zero latency; produces a one-cycle stall.
- IDLE, evaluated in priority order:
  1. branch_taken → o_flush=1, o_stall=0 (load-use and mul/div start ignored). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
  2. ex_muldiv_start → o_stall=1. If MULDIV_LATENCY>1, go to MULDIV with cnt=MULDIV_LATENCY-2.
  3. lu → o_stall=1; remain in IDLE.
- MULDIV:
  - o_stall=1, o_muldiv_busy=1.
  - branch_taken, ex_muldiv_start and lu are ignored.
  - If cnt==0 go to IDLE; otherwise decrement cnt.
  - Stall covers exactly MULDIV_LATENCY cycles, counting the start cycle.
- FLUSH:
  - o_flush=1, o_stall=0.
  - branch_taken, ex_muldiv_start and lu are ignored, since the EX/ID contents are squashed.
  - If cnt==0 go to IDLE; otherwise decrement cnt.
- Enables: o_pc_write_en = o_if_id_write_en = ~o_stall. During flush both are 1, so the PC loads the branch target.
- o_stall and o_flush are never both 1.
- Perf counters: increment on each cycle their signal is 1; hold at 2^CNT_W-1 (no wrap).
- Reset mid-operation: the FSM returns to IDLE on that edge and cnt is cleared. From the next cycle, outputs reflect only the inputs.

Test Plan:
1. ex_mem_read=1, ex_reg_write=1, ex_rd=5; id_valid=1, id_uses_rs2=1, id_rs2=5 for one cycle → o_stall=1 and o_pc_write_en=0 that cycle only. Repeat with ex_rd=0 → no stall.
2. MULDIV_LATENCY=4, one ex_muldiv_start pulse → o_stall=1 for exactly 4 consecutive cycles and o_muldiv_busy=1 for the last 3. A lu or branch_taken asserted mid-sequence has no effect. Stall counter reads 4.
3. FLUSH_CYCLES=2, branch_taken pulse → o_flush=1 for 2 cycles with o_stall=0 and o_pc_write_en=1. Flush counter reads 2.
4. branch_taken, ex_muldiv_start and a lu condition in the same IDLE cycle → flush only, o_stall=0, FSM enters FLUSH.
5. rst asserted in the 2nd cycle of MULDIV → the next cycle has o_stall=0, o_muldiv_busy=0, both counters=0.
6. CNT_W=4, hold lu for 20 cycles → o_stall_cycles saturates at 15.
